// File: rtl/demux1to4_deser_pkg.sv
// Shared lane constants, types and helpers for the 1-to-4 demultiplexing deserialiser.
package demux_pkg;
    localparam int NUM_LANES = 4;
    localparam int SEL_W     = 2;
    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    typedef logic [SEL_W-1:0] lane_idx_t;

    typedef enum logic {
        LANE_EMPTY = 1'b0,
        LANE_FULL  = 1'b1
    } lane_state_t;

    function automatic logic [NUM_LANES-1:0] lane_onehot(input lane_idx_t idx);
        logic [NUM_LANES-1:0] one;
        one = NUM_LANES'(1);
        return one << idx;
    endfunction
endpackage

// File: rtl/demux1to4_deser_if.sv
// Serial input and per-lane word output bundle of the deserialiser.
interface demux1to4_deser_if #(parameter int WIDTH = 8);
    import demux_pkg::*;

    logic                       in_valid;
    logic                       in_bit;
    lane_idx_t                  sel;
    logic                       in_ready;
    logic                       flush;
    logic [NUM_LANES*WIDTH-1:0] out_data;
    logic [NUM_LANES-1:0]       out_valid;
    logic [NUM_LANES-1:0]       out_ready;

    modport master (
        output in_valid, in_bit, sel, flush, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_valid, in_bit, sel, flush, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/demux1to4_deser_lane.sv
// One deserialiser lane: LSB-first shift register, bit counter, held output word.
//   state      | meaning
//   LANE_EMPTY | no word held, out_valid low
//   LANE_FULL  | completed word held in output reg until consumer takes it
module demux_lane
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             bit_en,
    input  logic             in_bit,
    input  logic             out_ready,
    output logic [WIDTH-1:0] word,
    output logic             valid,
    output logic             stall
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] shreg;
    lane_state_t      state;
    lane_state_t      state_nxt;
    logic             last;
    logic             complete;

    assign last     = (cnt == LAST);
    assign complete = bit_en & last;
    assign valid    = (state == LANE_FULL);
    // A completing bit may only enter when the held word leaves this same cycle.
    assign stall    = last & valid & ~out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            shreg <= '0;
        end else if (flush) begin
            cnt   <= '0;
            shreg <= '0;
        end else if (bit_en) begin
            shreg[cnt] <= in_bit;
            cnt        <= last ? '0 : cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word <= '0;
        end else if (complete) begin
            word <= {in_bit, shreg[WIDTH-2:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LANE_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LANE_EMPTY: if (complete) state_nxt = LANE_FULL;
            LANE_FULL: begin
                if (complete) begin
                    state_nxt = LANE_FULL;
                end else if (out_ready) begin
                    state_nxt = LANE_EMPTY;
                end
            end
            default: state_nxt = LANE_EMPTY;
        endcase
    end
endmodule

// File: rtl/demux1to4_deser.sv
// 1-to-4 deserialiser: steers each accepted serial bit into the lane chosen by sel.
module demux1to4_deser
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic              clk,
    input logic              rst,
    demux1to4_deser_if.slave bus
);
    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("demux1to4_deser: WIDTH out of range");
    end

    logic [NUM_LANES-1:0] stall;
    logic [NUM_LANES-1:0] bit_en;
    logic                 in_ready;
    logic                 accept;

    // Only the addressed lane can stall the input; flush swallows the bit.
    assign in_ready     = ~stall[bus.sel];
    assign bus.in_ready = in_ready;
    assign accept       = bus.in_valid & in_ready & ~bus.flush;
    assign bit_en       = accept ? lane_onehot(bus.sel) : '0;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        demux_lane #(.WIDTH(WIDTH)) u_lane (
            .clk       (clk),
            .rst       (rst),
            .flush     (bus.flush),
            .bit_en    (bit_en[k]),
            .in_bit    (bus.in_bit),
            .out_ready (bus.out_ready[k]),
            .word      (bus.out_data[k*WIDTH +: WIDTH]),
            .valid     (bus.out_valid[k]),
            .stall     (stall[k])
        );
    end
endmodule

// File: tb/tb_demux1to4_deser.sv
// Scoreboard bench: word-level lane model pushes expected words, a monitor pops on output handshakes.
module tb_demux1to4_deser;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    demux1to4_deser_if #(.WIDTH(W)) bus ();
    demux1to4_deser #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int failures = 0;
    bit mon_en = 1'b0;

    logic [W-1:0] exp_q [4][$];
    int           cnt_m [4];
    logic [W-1:0] acc_m [4];

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 4; k++) begin
            exp_q[k].delete();
            cnt_m[k] = 0;
            acc_m[k] = '0;
        end
    endtask

    // One clock: drive at negedge, check in_ready, update model, commit completed word after the edge.
    task automatic cycle(input bit r, input bit v, input bit b, input int s,
                         input bit f, input logic [3:0] ordy, output bit accepted);
        bit           exp_rdy;
        bit           pend;
        int           pl;
        logic [W-1:0] pw;
        @(negedge clk);
        rst = r;
        bus.in_valid = v;
        bus.in_bit = b;
        bus.sel = 2'(s);
        bus.flush = f;
        bus.out_ready = ordy;
        #1;
        exp_rdy = !(cnt_m[s] == W - 1 && exp_q[s].size() > 0 && !ordy[s]);
        check("in_ready", longint'(bus.in_ready), longint'(exp_rdy));
        pend = 1'b0;
        pl = 0;
        pw = '0;
        accepted = !r && !f && v && exp_rdy;
        if (accepted) begin
            if (cnt_m[s] == 0) acc_m[s] = '0;
            acc_m[s] = acc_m[s] | (W'(b) << cnt_m[s]);
            if (cnt_m[s] == W - 1) begin
                pend = 1'b1;
                pl = s;
                pw = acc_m[s];
                cnt_m[s] = 0;
            end else begin
                cnt_m[s]++;
            end
        end
        if (f && !r) for (int k = 0; k < 4; k++) cnt_m[k] = 0;
        @(posedge clk);
        #1;
        if (r) model_clear();
        else if (pend) exp_q[pl].push_back(pw);
    endtask

    task automatic idle(input int n, input logic [3:0] ordy);
        bit a;
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, ordy, a);
    endtask

    task automatic send_bit(input int lane, input bit b, input logic [3:0] ordy);
        bit a;
        int tries = 0;
        do begin
            cycle(0, 1, b, lane, 0, ordy, a);
            tries++;
        end while (!a && tries < 50);
        if (!a) check("send_timeout", 0, 1);
    endtask

    task automatic send_word(input int lane, input logic [W-1:0] w, input logic [3:0] ordy);
        for (int i = 0; i < W; i++) send_bit(lane, w[i], ordy);
    endtask

    // Monitor: DUT valid must match a pending expected word; data must equal queue head until drained.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                for (int k = 0; k < 4; k++) begin
                    check($sformatf("out_valid[%0d]", k), longint'(bus.out_valid[k]),
                          longint'(exp_q[k].size() > 0));
                    if (bus.out_valid[k] === 1'b1 && exp_q[k].size() > 0) begin
                        check($sformatf("out_data[%0d]", k),
                              longint'(bus.out_data[k*W +: W]), longint'(exp_q[k][0]));
                        if (bus.out_ready[k]) void'(exp_q[k].pop_front());
                    end
                end
            end
        end
    end

    initial begin
        bit a;
        logic [W-1:0] c3;
        model_clear();
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_bit = 1'b1;
        bus.sel = 2'd0;
        bus.flush = 1'b0;
        bus.out_ready = 4'hF;

        // Reset with input active
        cycle(1, 1, 1, 0, 0, 4'hF, a);
        cycle(1, 1, 1, 2, 0, 4'hF, a);
        check("rst_out_valid", longint'(bus.out_valid), 0);
        check("rst_out_data", longint'(bus.out_data), 0);
        check("rst_in_ready", longint'(bus.in_ready), 1);
        mon_en = 1'b1;

        // Single lane A5 on lane 2
        send_word(2, 8'hA5, 4'hF);
        idle(3, 4'hF);

        // Round-robin interleave
        for (int i = 0; i < W; i++)
            for (int k = 0; k < 4; k++) begin
                logic [W-1:0] w;
                w = W'(8'h11 * (k + 1));
                send_bit(k, w[i], 4'hF);
            end
        idle(3, 4'hF);

        // Backpressure on lane 1
        send_word(1, 8'h3C, 4'b1101);
        c3 = 8'hC3;
        for (int i = 0; i < W - 1; i++) send_bit(1, c3[i], 4'b1101);
        cycle(0, 1, c3[W-1], 1, 0, 4'b1101, a);
        check("stall_sel1", longint'(a), 0);
        cycle(0, 0, 0, 0, 0, 4'b1101, a);
        cycle(0, 1, c3[W-1], 1, 0, 4'hF, a);
        check("b2b_accept", longint'(a), 1);
        idle(3, 4'hF);

        // Flush with a held word on lane 0
        send_word(0, 8'h5A, 4'b1110);
        for (int i = 0; i < 5; i++) send_bit(3, i[0], 4'b1110);
        cycle(0, 1, 1, 3, 1, 4'b1110, a);
        send_word(3, 8'hF0, 4'b1110);
        idle(2, 4'b1110);
        idle(3, 4'hF);

        // Reset mid-operation
        send_word(0, 8'h96, 4'b1110);
        for (int i = 0; i < 4; i++) send_bit(2, 1'b1, 4'b1110);
        cycle(1, 1, 1, 2, 0, 4'b1110, a);
        check("midrst_valid", longint'(bus.out_valid), 0);
        send_word(2, 8'h77, 4'hF);
        idle(3, 4'hF);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 499) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
                  $urandom_range(0, 3), ($urandom_range(0, 31) == 0), 4'($urandom), a);
        end
        idle(4, 4'hF);
        for (int k = 0; k < 4; k++) check($sformatf("drained[%0d]", k), exp_q[k].size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
